ts_injection_management: RTL and testbench

TS_INJECTION_MANAGEMENT -- requirements
Module: ts_injection_management

---
 rtl/ts_injection_management_pkg.sv | 19 +
 rtl/ts_injection_management_sdpram.sv | 49 ++++
 rtl/ts_injection_management.sv | 154 +++++++++++++++
 tb/tb_ts_injection_management.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_injection_management_pkg.sv
// Shared TSN definitions for the injection-management block: FSM encodings,
// default widths and the descriptor-buffer geometry.
package ts_injection_management_pkg;

  localparam int TIM_DESC_W = 40;
  localparam int TIM_CNT_W  = 16;
  localparam int TIM_DEPTH  = 32;
  localparam int TIM_ADDR_W = 5;

  typedef enum logic [2:0] {
    TIM_IDLE        = 3'd0,
    TIM_READ        = 3'd1,
    TIM_WAIT_FIRST  = 3'd2,
    TIM_WAIT_SECOND = 3'd3,
    TIM_CHECK       = 3'd4,
    TIM_WAIT_ACK    = 3'd5
  } tim_state_e;

endpackage

// File: rtl/ts_injection_management_sdpram.sv
// Simple dual-port descriptor RAM: 2-cycle registered read, read-before-write
// on a same-address collision, asynchronous clear of the read pipeline control.
module sdpram32x40_rq
  import ts_injection_management_pkg::*;
#(
  parameter int DATA_W = TIM_DESC_W
) (
  input  logic                  clk_i,
  input  logic                  aclr_n_i,
  input  logic                  wr_en_i,
  input  logic [TIM_ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic                  rd_en_i,
  input  logic [TIM_ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0]     rd_data_o
);

  logic [DATA_W-1:0] mem_q [TIM_DEPTH];
  logic [DATA_W-1:0] rd_data_p1;
  logic [DATA_W-1:0] rd_data_p2;
  logic              vld_p1;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge aclr_n_i) begin
    if (!aclr_n_i) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_en_i;
    end
  end

  // Stage 1: array read (sees pre-write contents); stage 2: output register
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_data_p1 <= mem_q[rd_addr_i];
    end
    if (vld_p1) begin
      rd_data_p2 <= rd_data_p1;
    end
  end

  assign rd_data_o = rd_data_p2;

endmodule

// File: rtl/ts_injection_management.sv
// Serves scheduler injection requests from a 32-entry descriptor buffer,
// forwarding valid descriptors downstream and counting requests for empty slots.
module ts_injection_management
  import ts_injection_management_pkg::*;
#(
  parameter int DESC_W = TIM_DESC_W,
  parameter int CNT_W  = TIM_CNT_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [TIM_ADDR_W-1:0] iv_ts_injection_addr,
  input  logic                  i_ts_injection_addr_wr,
  output logic                  o_ts_injection_addr_ack,
  input  logic [DESC_W-1:0]     iv_ts_descriptor_wdata,
  input  logic [TIM_ADDR_W-1:0] iv_ts_descriptor_waddr,
  input  logic                  i_ts_descriptor_wr,
  output logic [DESC_W-1:0]     ov_ts_descriptor,
  output logic                  o_ts_descriptor_wr,
  input  logic                  i_ts_descriptor_ack,
  output logic [CNT_W-1:0]      ov_discard_cnt,
  output logic [2:0]            ov_tim_state
);

  tim_state_e              state_q, state_d;
  logic [TIM_ADDR_W-1:0]   addr_q;
  logic                    ack_q;
  logic [TIM_DEPTH-1:0]    valid_q, valid_d;
  logic                    load_p1;
  logic [DESC_W-1:0]       desc_q;
  logic                    desc_wr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DESC_W-1:0]       ram_rdata;

  logic accept;
  logic rd_en;
  logic hit;
  logic miss;
  logic retire;
  logic bad_state;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  sdpram32x40_rq #(
    .DATA_W (DESC_W)
  ) u_ram (
    .clk_i     (i_clk),
    .aclr_n_i  (i_rst_n),
    .wr_en_i   (i_ts_descriptor_wr),
    .wr_addr_i (iv_ts_descriptor_waddr),
    .wr_data_i (iv_ts_descriptor_wdata),
    .rd_en_i   (rd_en),
    .rd_addr_i (addr_q),
    .rd_data_o (ram_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= TIM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TIM_IDLE:        if (i_ts_injection_addr_wr) state_d = TIM_READ;
      TIM_READ:        state_d = TIM_WAIT_FIRST;
      TIM_WAIT_FIRST:  state_d = TIM_WAIT_SECOND;
      TIM_WAIT_SECOND: state_d = TIM_CHECK;
      TIM_CHECK:       state_d = valid_q[addr_q] ? TIM_WAIT_ACK : TIM_IDLE;
      // Only an ack against a presented descriptor closes the transaction
      TIM_WAIT_ACK:    if (i_ts_descriptor_ack && desc_wr_q) state_d = TIM_IDLE;
      default:         state_d = TIM_IDLE;
    endcase
  end

  always_comb begin
    accept    = 1'b0;
    rd_en     = 1'b0;
    hit       = 1'b0;
    miss      = 1'b0;
    retire    = 1'b0;
    bad_state = 1'b0;
    case (state_q)
      TIM_IDLE:        accept = i_ts_injection_addr_wr;
      TIM_READ:        rd_en  = 1'b1;
      TIM_WAIT_FIRST:  ;
      TIM_WAIT_SECOND: ;
      TIM_CHECK: begin
        hit  = valid_q[addr_q];
        miss = ~valid_q[addr_q];
      end
      TIM_WAIT_ACK:    retire = i_ts_descriptor_ack & desc_wr_q;
      default:         bad_state = 1'b1;
    endcase
  end

  // A host write landing on the entry being consumed re-arms it
  always_comb begin
    valid_d = valid_q;
    if (hit) begin
      valid_d[addr_q] = 1'b0;
    end
    if (i_ts_descriptor_wr) begin
      valid_d[iv_ts_descriptor_waddr] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= '0;
      load_p1 <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ack_q   <= accept;
      valid_q <= valid_d;
      load_p1 <= hit;
      if (accept) begin
        addr_q <= iv_ts_injection_addr;
      end
      if (bad_state) begin
        cnt_q <= '0;
      end else if (miss) begin
        cnt_q <= sat_inc(cnt_q);
      end
    end
  end

  // Output stage: registered off the CHECK decision, held until retired
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      desc_wr_q <= 1'b0;
      desc_q    <= '0;
    end else if (bad_state || retire) begin
      desc_wr_q <= 1'b0;
      desc_q    <= '0;
    end else if (load_p1) begin
      desc_wr_q <= 1'b1;
      desc_q    <= ram_rdata;
    end
  end

  assign o_ts_injection_addr_ack = ack_q;
  assign ov_ts_descriptor        = desc_q;
  assign o_ts_descriptor_wr      = desc_wr_q;
  assign ov_discard_cnt          = cnt_q;
  assign ov_tim_state            = state_q;

endmodule

// File: tb/tb_ts_injection_management.sv
// Directed bench for ts_injection_management with a scoreboard of expected
// request outcomes; a second instance with a 3-bit counter exercises saturation.
module tb_ts_injection_management;

  localparam int DESC_W = 40;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [4:0]        req_addr;
  logic              req_wr;
  logic [DESC_W-1:0] wdata;
  logic [4:0]        waddr;
  logic              dwr;
  logic              desc_ack;

  logic              ack;
  logic [DESC_W-1:0] desc;
  logic              desc_wr;
  logic [15:0]       cnt;
  logic [2:0]        state;

  logic              sat_ack;
  logic [DESC_W-1:0] sat_desc;
  logic              sat_desc_wr;
  logic [2:0]        sat_cnt;
  logic [2:0]        sat_state;

  int checks = 0;
  int errors = 0;

  logic [DESC_W-1:0] m_mem [32];
  logic [31:0]       m_valid;
  int                m_cnt;

  typedef struct packed {
    logic              hit;
    logic [DESC_W-1:0] data;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  ts_injection_management #(.DESC_W(DESC_W), .CNT_W(16)) dut (
    .i_clk                  (clk),
    .i_rst_n                (rst_n),
    .iv_ts_injection_addr   (req_addr),
    .i_ts_injection_addr_wr (req_wr),
    .o_ts_injection_addr_ack(ack),
    .iv_ts_descriptor_wdata (wdata),
    .iv_ts_descriptor_waddr (waddr),
    .i_ts_descriptor_wr     (dwr),
    .ov_ts_descriptor       (desc),
    .o_ts_descriptor_wr     (desc_wr),
    .i_ts_descriptor_ack    (desc_ack),
    .ov_discard_cnt         (cnt),
    .ov_tim_state           (state)
  );

  ts_injection_management #(.DESC_W(DESC_W), .CNT_W(3)) dut_sat (
    .i_clk                  (clk),
    .i_rst_n                (rst_n),
    .iv_ts_injection_addr   (req_addr),
    .i_ts_injection_addr_wr (req_wr),
    .o_ts_injection_addr_ack(sat_ack),
    .iv_ts_descriptor_wdata (wdata),
    .iv_ts_descriptor_waddr (waddr),
    .i_ts_descriptor_wr     (dwr),
    .ov_ts_descriptor       (sat_desc),
    .o_ts_descriptor_wr     (sat_desc_wr),
    .i_ts_descriptor_ack    (desc_ack),
    .ov_discard_cnt         (sat_cnt),
    .ov_tim_state           (sat_state)
  );

  function automatic int sat7(input int c);
    return (c > 7) ? 7 : c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [4:0] a, input logic [DESC_W-1:0] d);
    waddr = a;
    wdata = d;
    dwr   = 1'b1;
    tick();
    dwr        = 1'b0;
    m_mem[a]   = d;
    m_valid[a] = 1'b1;
  endtask

  // Edges N+1..N+5 of a request already accepted at edge N; optional host
  // write to the same entry on edge N+coll_edge.
  task automatic req_tail(input logic [4:0] a, input int coll_edge, input logic [DESC_W-1:0] coll_data);
    exp_t e;
    e.hit  = m_valid[a];
    e.data = m_mem[a];
    sb.push_back(e);
    for (int k = 1; k <= 5; k++) begin
      if (k == coll_edge) begin
        waddr = a;
        wdata = coll_data;
        dwr   = 1'b1;
      end
      tick();
      if (k == 1) begin
        chk("ack_single", 64'(ack), 64'(1'b0));
        req_wr = 1'b0;
      end
      if (k == 4) begin
        chk("latency_early", 64'(desc_wr), 64'(1'b0));
        if (e.hit) m_valid[a] = 1'b0;
        else m_cnt++;
      end
      if (k == coll_edge) begin
        dwr        = 1'b0;
        m_mem[a]   = coll_data;
        m_valid[a] = 1'b1;
      end
    end
    e = sb.pop_front();
    if (e.hit) begin
      chk("hit_wr", 64'(desc_wr), 64'(1'b1));
      chk("hit_data", 64'(desc), 64'(e.data));
      chk("sat_hit_wr", 64'(sat_desc_wr), 64'(1'b1));
      chk("sat_hit_data", 64'(sat_desc), 64'(e.data));
    end else begin
      chk("miss_wr", 64'(desc_wr), 64'(1'b0));
      chk("miss_cnt", 64'(cnt), 64'(m_cnt));
      chk("miss_sat_cnt", 64'(sat_cnt), 64'(sat7(m_cnt)));
      chk("miss_state", 64'(state), 64'(0));
      chk("miss_sat_state", 64'(sat_state), 64'(0));
    end
  endtask

  task automatic request(input logic [4:0] a, input int coll_edge, input logic [DESC_W-1:0] coll_data);
    req_addr = a;
    req_wr   = 1'b1;
    tick();
    chk("ack_pulse", 64'(ack), 64'(1'b1));
    chk("sat_ack_pulse", 64'(sat_ack), 64'(1'b1));
    req_tail(a, coll_edge, coll_data);
  endtask

  task automatic release_ds();
    desc_ack = 1'b1;
    tick();
    chk("rel_wr", 64'(desc_wr), 64'(1'b0));
    chk("rel_desc", 64'(desc), 64'(0));
    chk("rel_state", 64'(state), 64'(0));
    desc_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b1;
    req_addr = '0;
    req_wr   = 1'b0;
    wdata    = '0;
    waddr    = '0;
    dwr      = 1'b0;
    desc_ack = 1'b0;
    m_valid  = '0;
    m_cnt    = 0;

    #2 rst_n = 1'b0;
    #1;
    chk("reset_state", 64'(state), 64'(0));
    chk("reset_ack", 64'(ack), 64'(1'b0));
    chk("reset_wr", 64'(desc_wr), 64'(1'b0));
    chk("reset_desc", 64'(desc), 64'(0));
    chk("reset_cnt", 64'(cnt), 64'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Basic hit, then the consumed entry reads as empty
    host_write(5'd3, 40'h12_3456_789A);
    request(5'd3, 0, '0);
    release_ds();
    request(5'd3, 0, '0);

    // Empty entry
    request(5'd7, 0, '0);

    // Downstream back-pressure with a pending request
    host_write(5'd12, 40'hC0_FFEE_0012);
    request(5'd12, 0, '0);
    req_addr = 5'd9;
    req_wr   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_wr", 64'(desc_wr), 64'(1'b1));
      chk("hold_desc", 64'(desc), 64'(40'hC0_FFEE_0012));
      chk("hold_no_ack", 64'(ack), 64'(1'b0));
    end
    desc_ack = 1'b1;
    tick();
    desc_ack = 1'b0;
    chk("bp_rel_wr", 64'(desc_wr), 64'(1'b0));
    chk("bp_rel_desc", 64'(desc), 64'(0));
    chk("bp_ack_not_yet", 64'(ack), 64'(1'b0));
    tick();
    chk("bp_ack_after", 64'(ack), 64'(1'b1));
    req_tail(5'd9, 0, '0);

    // Host write coinciding with the CHECK clear: old data out, entry stays valid
    host_write(5'd3, 40'hA5_A5A5_A5A5);
    request(5'd3, 4, 40'h5A_0000_0003);
    release_ds();
    request(5'd3, 0, '0);
    release_ds();

    // Host write on the RAM read edge: old data out, entry cleared by CHECK
    host_write(5'd3, 40'h11_1111_1111);
    request(5'd3, 1, 40'h22_2222_2222);
    release_ds();
    request(5'd3, 0, '0);

    // Reset in WAIT_SECOND abandons the transaction and empties the buffer
    host_write(5'd10, 40'h0A_0B0C_0D0E);
    req_addr = 5'd10;
    req_wr   = 1'b1;
    tick();
    chk("rst_ack", 64'(ack), 64'(1'b1));
    tick();
    req_wr = 1'b0;
    tick();
    chk("rst_in_wait_second", 64'(state), 64'(3));
    rst_n = 1'b0;
    #1;
    chk("rst_state", 64'(state), 64'(0));
    chk("rst_ack_clr", 64'(ack), 64'(1'b0));
    chk("rst_wr", 64'(desc_wr), 64'(1'b0));
    chk("rst_desc", 64'(desc), 64'(0));
    chk("rst_cnt", 64'(cnt), 64'(0));
    chk("rst_sat_cnt", 64'(sat_cnt), 64'(0));
    m_valid = '0;
    m_cnt   = 0;
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    request(5'd10, 0, '0);

    // Discard counter saturation (3-bit instance pins at 7)
    for (int i = 0; i < 8; i++) begin
      request(5'd20, 0, '0);
    end
    chk("sat_hold", 64'(sat_cnt), 64'(7));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
